// File: rtl/rom_port_arbiter_if.sv
// Request/grant/response bundle between the CPU core ports (IF, DM) and the
// shared program ROM.
interface rom_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [WIDTH-1:0] if_rdata;
  logic             dm_req;
  logic [WIDTH-1:0] dm_addr;
  logic             dm_gnt;
  logic             dm_rvalid;
  logic [WIDTH-1:0] dm_rdata;
  logic             dm_err;
  logic [WIDTH-1:0] rom_addr;
  logic [WIDTH-1:0] rom_rdata;

  // master: core side plus ROM data source; slave: the arbiter
  modport master (
    output if_req, if_addr, dm_req, dm_addr, rom_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, dm_err, rom_addr
  );
  modport slave (
    input  if_req, if_addr, dm_req, dm_addr, rom_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, dm_err, rom_addr
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares one asynchronous program ROM between instruction fetch and data load,
// with a starvation guard that periodically hands priority to fetch.
module rom_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2048,
  parameter int STARVE_MAX = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  rom_port_arbiter_if.slave   bus
);
  localparam int CW = $clog2(STARVE_MAX) + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(STARVE_MAX - 1);
  localparam logic [WIDTH-1:0] DEPTH_W  = WIDTH'(DEPTH);

  typedef enum logic {PRIO_DM, PRIO_IF} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_wait_cnt;
  logic             r_if_rvalid, r_dm_rvalid, r_dm_err;
  logic [WIDTH-1:0] r_if_rdata, r_dm_rdata;
  logic             w_if_gnt, w_dm_gnt, w_if_blocked, w_if_oor, w_dm_oor;
  logic [WIDTH-1:0] w_rom_addr;

  // Word index compared against DEPTH; byte-lane bits are ignored.
  assign w_if_oor = {2'b00, bus.if_addr[WIDTH-1:2]} >= DEPTH_W;
  assign w_dm_oor = {2'b00, bus.dm_addr[WIDTH-1:2]} >= DEPTH_W;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= PRIO_DM;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_if_gnt    = 1'b0;
    w_dm_gnt    = 1'b0;
    w_state_nxt = r_state;
    if (!i_reset) begin
      case (r_state)
        PRIO_DM: begin
          w_dm_gnt = bus.dm_req;
          w_if_gnt = bus.if_req & ~bus.dm_req;
          if (bus.if_req && !w_if_gnt && r_wait_cnt == CNT_LAST)
            w_state_nxt = PRIO_IF;
        end
        PRIO_IF: begin
          w_if_gnt = bus.if_req;
          w_dm_gnt = bus.dm_req & ~bus.if_req;
          if (w_if_gnt || !bus.if_req)
            w_state_nxt = PRIO_DM;
        end
        default: w_state_nxt = PRIO_DM;
      endcase
    end
  end

  assign w_if_blocked = bus.if_req & ~w_if_gnt;

  always_comb begin
    w_rom_addr = '0;
    if (w_dm_gnt)      w_rom_addr = w_dm_oor ? '0 : bus.dm_addr;
    else if (w_if_gnt) w_rom_addr = bus.if_addr;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)           r_wait_cnt <= '0;
    else if (w_if_blocked) r_wait_cnt <= r_wait_cnt + 1'b1;
    else                   r_wait_cnt <= '0;
  end

  // rdata registers only load on a grant so they hold between responses.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rvalid <= 1'b0;
      r_dm_rdata  <= '0;
      r_dm_err    <= 1'b0;
    end else begin
      r_if_rvalid <= w_if_gnt;
      r_dm_rvalid <= w_dm_gnt;
      r_dm_err    <= w_dm_gnt & w_dm_oor;
      if (w_if_gnt) r_if_rdata <= w_if_oor ? '0 : bus.rom_rdata;
      if (w_dm_gnt) r_dm_rdata <= w_dm_oor ? '0 : bus.rom_rdata;
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.dm_gnt    = w_dm_gnt;
  assign bus.rom_addr  = w_rom_addr;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rvalid = r_dm_rvalid;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.dm_err    = r_dm_err;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: ROM model, per-port response queues.
module tb_rom_port_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t        if_q[$];
  rsp_t        dm_q[$];
  logic [31:0] last_if = '0;
  logic [31:0] last_dm = '0;

  rom_port_arbiter_if #(.WIDTH(WIDTH)) bus ();

  rom_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_MAX(4)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [29:0] w);
    return {w[15:0] ^ 16'hC3A5, w[15:0] + 16'h0101};
  endfunction

  assign bus.rom_rdata = rom_word(bus.rom_addr[31:2]);

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return (a[31:2] >= 30'(DEPTH)) ? 32'h0 : rom_word(a[31:2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, then record what
  // the grant obliges the DUT to return next cycle.
  task automatic cyc(input logic ireq, input logic [31:0] iaddr,
                     input logic dreq, input logic [31:0] daddr,
                     input logic eig, input logic edg, input logic [31:0] era);
    rsp_t r;
    @(posedge clk); #1;
    bus.if_req = ireq; bus.if_addr = iaddr;
    bus.dm_req = dreq; bus.dm_addr = daddr;
    @(negedge clk);
    chk("if_gnt", {31'b0, bus.if_gnt}, {31'b0, eig});
    chk("dm_gnt", {31'b0, bus.dm_gnt}, {31'b0, edg});
    chk("rom_addr", bus.rom_addr, era);
    chk("if_rvalid", {31'b0, bus.if_rvalid}, {31'b0, (if_q.size() > 0)});
    if (if_q.size() > 0) begin
      r = if_q.pop_front();
      last_if = r.data;
    end
    chk("if_rdata", bus.if_rdata, last_if);
    chk("dm_rvalid", {31'b0, bus.dm_rvalid}, {31'b0, (dm_q.size() > 0)});
    if (dm_q.size() > 0) begin
      r = dm_q.pop_front();
      last_dm = r.data;
      chk("dm_err", {31'b0, bus.dm_err}, {31'b0, r.err});
    end else begin
      chk("dm_err_idle", {31'b0, bus.dm_err}, 32'h0);
    end
    chk("dm_rdata", bus.dm_rdata, last_dm);
    if (eig) if_q.push_back('{data: exp_data(iaddr), err: 1'b0});
    if (edg) dm_q.push_back('{data: exp_data(daddr), err: (daddr[31:2] >= 30'(DEPTH))});
  endtask

  initial begin
    // reset with both requests high
    bus.if_req = 1'b1; bus.if_addr = 32'h4;
    bus.dm_req = 1'b1; bus.dm_addr = 32'h8;
    #1;
    chk("rst_if_gnt", {31'b0, bus.if_gnt}, 32'h0);
    chk("rst_dm_gnt", {31'b0, bus.dm_gnt}, 32'h0);
    chk("rst_rom_addr", bus.rom_addr, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'h0);
    chk("rst_dm_rvalid", {31'b0, bus.dm_rvalid}, 32'h0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'h0);
    chk("rst_dm_err", {31'b0, bus.dm_err}, 32'h0);
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    rst = 1'b0;

    // single IF read
    cyc(1, 32'h4, 0, 0, 1, 0, 32'h4);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);

    // simultaneous requests: DM first, IF next
    cyc(1, 32'h0, 1, 32'h8, 0, 1, 32'h8);
    cyc(1, 32'h0, 0, 0, 1, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);

    // starvation guard: DM held, IF forced through on the fifth cycle
    cyc(1, 32'h20, 1, 32'h10, 0, 1, 32'h10);
    cyc(1, 32'h20, 1, 32'h14, 0, 1, 32'h14);
    cyc(1, 32'h20, 1, 32'h18, 0, 1, 32'h18);
    cyc(1, 32'h20, 1, 32'h1C, 0, 1, 32'h1C);
    cyc(1, 32'h20, 1, 32'h30, 1, 0, 32'h20);
    cyc(1, 32'h24, 1, 32'h30, 0, 1, 32'h30);
    cyc(1, 32'h24, 0, 0, 1, 0, 32'h24);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);

    // DM range boundary: last word valid, first word past end errors
    cyc(0, 0, 1, 32'h1FFC, 0, 1, 32'h1FFC);
    cyc(0, 0, 1, 32'h2000, 0, 1, 32'h0);
    cyc(0, 0, 1, 32'h2003, 0, 1, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);

    // IF out of range returns zero; back-to-back IF grants; ignored low bits
    cyc(1, 32'h4000, 0, 0, 1, 0, 32'h4000);
    cyc(1, 32'hC, 0, 0, 1, 0, 32'hC);
    cyc(1, 32'h13, 0, 0, 1, 0, 32'h13);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);

    // IF request dropped before grant leaves no response
    cyc(1, 32'h40, 1, 32'h44, 0, 1, 32'h44);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);

    // reset between grant and response discards the response
    cyc(1, 32'h8, 0, 0, 1, 0, 32'h8);
    #1 rst = 1'b1;
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    if_q.delete(); dm_q.delete();
    last_if = '0; last_dm = '0;
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    cyc(1, 32'h4, 0, 0, 1, 0, 32'h4);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
